alu_seq_core: RTL and testbench

Parametrised, handshaked successor to the single-cycle ALU. It adds an iterative multiplier/divider, a result accumulator, valid/ready flow control and a clock enable. It sits between the tile I/O adapter (ui_in/uio_in/uo_out packing) and the top-level wrapper. Operand width is a parameter, and the same core serves the 8-bit tile and wider internal builds.

---
 rtl/alu_pkg.sv | 33 +++
 rtl/alu_seq_core_if.sv | 27 ++
 rtl/alu_seq_muldiv.sv | 117 +++++++++++
 rtl/alu_seq_core.sv | 192 +++++++++++++++++++
 tb/tb_alu_seq_core.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the sequential ALU core (opcodes, FSM states, flag indices).
// Divide support is selected at build time with ALU_DIV_EN.
package alu_pkg;

  localparam int unsigned OP_W   = 4;
  localparam int unsigned FLAG_W = 4;

  localparam int unsigned FLAG_Z = 3;
  localparam int unsigned FLAG_N = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  typedef enum logic [OP_W-1:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_AND   = 4'd2,
    OP_OR    = 4'd3,
    OP_XOR   = 4'd4,
    OP_SHL   = 4'd5,
    OP_SHR   = 4'd6,
    OP_SRA   = 4'd7,
    OP_MUL   = 4'd8,
    OP_DIV   = 4'd9,
    OP_PASSB = 4'd10
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

endpackage

// File: rtl/alu_seq_core_if.sv
// Command/result handshake bundle between the tile adapter (master) and alu_seq_core (slave).
interface alu_seq_core_if #(parameter int unsigned WIDTH = 8);
  import alu_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [OP_W-1:0]   op;
  logic              acc_sel;
  logic [WIDTH-1:0]  a;
  logic [WIDTH-1:0]  b;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  result;
  logic [WIDTH-1:0]  result_hi;
  logic [FLAG_W-1:0] flags;

  modport master (
    output in_valid, op, acc_sel, a, b, out_ready,
    input  in_ready, out_valid, result, result_hi, flags
  );

  modport slave (
    input  in_valid, op, acc_sel, a, b, out_ready,
    output in_ready, out_valid, result, result_hi, flags
  );

endinterface

// File: rtl/alu_seq_muldiv.sv
// Iterative engine: WIDTH shift-add (MUL) or restoring-subtract (DIV) steps, first step on the start edge.
// The divider datapath exists only when ALU_DIV_EN is defined.
module alu_seq_muldiv #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena_i,
  input  logic             start_i,
`ifdef ALU_DIV_EN
  input  logic             div_i,
`endif
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] lo_o,
  output logic [WIDTH-1:0] hi_o
);

  localparam int unsigned CW = $clog2(WIDTH);

  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;

  logic [WIDTH-1:0] hi_src, lo_src, opnd_src;
  logic [WIDTH:0]   add_sum;
`ifdef ALU_DIV_EN
  logic             div_q, div_d, div_src;
  logic [WIDTH:0]   div_shift, div_trial;
`endif

  // Step operates on fresh operands at start, otherwise on the running partial state
  always_comb begin
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    hi_d     = hi_q;
    lo_d     = lo_q;
    opnd_d   = opnd_q;
    hi_src   = start_i ? '0  : hi_q;
    lo_src   = start_i ? a_i : lo_q;
    opnd_src = start_i ? b_i : opnd_q;
    add_sum  = {1'b0, hi_src} + (lo_src[0] ? {1'b0, opnd_src} : '0);
`ifdef ALU_DIV_EN
    div_d     = div_q;
    div_src   = start_i ? div_i : div_q;
    div_shift = {hi_src, lo_src[WIDTH-1]};
    div_trial = div_shift - {1'b0, opnd_src};
`endif

    if (start_i || busy_q) begin
      opnd_d = opnd_src;
`ifdef ALU_DIV_EN
      div_d = div_src;
      if (div_src) begin
        // Restoring divide: hi holds the remainder, lo shifts dividend out and quotient in
        if (!div_trial[WIDTH]) begin
          hi_d = div_trial[WIDTH-1:0];
          lo_d = {lo_src[WIDTH-2:0], 1'b1};
        end else begin
          hi_d = div_shift[WIDTH-1:0];
          lo_d = {lo_src[WIDTH-2:0], 1'b0};
        end
      end else begin
        {hi_d, lo_d} = {add_sum, lo_src[WIDTH-1:1]};
      end
`else
      {hi_d, lo_d} = {add_sum, lo_src[WIDTH-1:1]};
`endif
      if (start_i) begin
        busy_d = 1'b1;
        cnt_d  = CW'(1);
      end else if (cnt_q == CW'(WIDTH - 1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      opnd_q <= '0;
`ifdef ALU_DIV_EN
      div_q  <= 1'b0;
`endif
    end else if (ena_i) begin
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      opnd_q <= opnd_d;
`ifdef ALU_DIV_EN
      div_q  <= div_d;
`endif
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign lo_o   = lo_q;
  assign hi_o   = hi_q;

endmodule

// File: rtl/alu_seq_core.sv
// Handshaked ALU: IDLE/EXEC/HOLD control, single-cycle ops, accumulator and flags around alu_seq_muldiv.
// Define ALU_DIV_EN to build the unsigned divider; otherwise opcode 9 decodes as illegal.
module alu_seq_core
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ena,
  alu_seq_core_if.slave bus
);

  localparam int unsigned SW = $clog2(WIDTH);

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  result_q, result_d;
  logic [WIDTH-1:0]  hi_q, hi_d;
  logic [WIDTH-1:0]  acc_q, acc_d;
  logic [FLAG_W-1:0] flags_q, flags_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic              in_ready_q, out_valid_q;
  logic              start_c;

  logic [WIDTH-1:0]  opa_c;
  logic [SW-1:0]     sh_c;
  logic [WIDTH:0]    add_c, sub_c, shl_c, shr_c, sra_c;
  logic [WIDTH-1:0]  alu_res_c, alu_hi_c;
  logic              alu_c_c, alu_v_c, alu_multi_c;
  logic [FLAG_W-1:0] alu_flags_c;

  logic              md_busy, md_done;
  logic [WIDTH-1:0]  md_lo, md_hi;

  assign opa_c = bus.acc_sel ? acc_q : bus.a;
  assign sh_c  = bus.b[SW-1:0];
  assign add_c = {1'b0, opa_c} + {1'b0, bus.b};
  assign sub_c = {1'b0, opa_c} - {1'b0, bus.b};
  // Extra bit beside the word catches the last bit shifted out
  assign shl_c = {1'b0, opa_c} << sh_c;
  assign shr_c = {opa_c, 1'b0} >> sh_c;
  assign sra_c = $signed({opa_c, 1'b0}) >>> sh_c;

  // Single-cycle results; MUL and DIV with a nonzero divisor are flagged for the engine
  always_comb begin
    alu_res_c   = '0;
    alu_hi_c    = '0;
    alu_c_c     = 1'b0;
    alu_v_c     = 1'b0;
    alu_multi_c = 1'b0;
    case (bus.op)
      OP_ADD: begin
        alu_res_c = add_c[WIDTH-1:0];
        alu_c_c   = add_c[WIDTH];
        alu_v_c   = (opa_c[WIDTH-1] == bus.b[WIDTH-1]) && (add_c[WIDTH-1] != opa_c[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res_c = sub_c[WIDTH-1:0];
        alu_c_c   = sub_c[WIDTH];
        alu_v_c   = (opa_c[WIDTH-1] != bus.b[WIDTH-1]) && (sub_c[WIDTH-1] != opa_c[WIDTH-1]);
      end
      OP_AND:   alu_res_c = opa_c & bus.b;
      OP_OR:    alu_res_c = opa_c | bus.b;
      OP_XOR:   alu_res_c = opa_c ^ bus.b;
      OP_SHL: begin
        alu_res_c = shl_c[WIDTH-1:0];
        alu_c_c   = shl_c[WIDTH];
      end
      OP_SHR: begin
        alu_res_c = shr_c[WIDTH:1];
        alu_c_c   = shr_c[0];
      end
      OP_SRA: begin
        alu_res_c = sra_c[WIDTH:1];
        alu_c_c   = sra_c[0];
      end
      OP_MUL:   alu_multi_c = 1'b1;
`ifdef ALU_DIV_EN
      OP_DIV: begin
        if (bus.b != '0) begin
          alu_multi_c = 1'b1;
        end else begin
          alu_res_c = '1;
          alu_hi_c  = opa_c;
          alu_v_c   = 1'b1;
        end
      end
`endif
      OP_PASSB: alu_res_c = bus.b;
      default:  alu_v_c = 1'b1;
    endcase
    alu_flags_c         = '0;
    alu_flags_c[FLAG_Z] = (alu_res_c == '0);
    alu_flags_c[FLAG_N] = alu_res_c[WIDTH-1];
    alu_flags_c[FLAG_C] = alu_c_c;
    alu_flags_c[FLAG_V] = alu_v_c;
  end

  // Next-state and result capture
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    hi_d     = hi_q;
    acc_d    = acc_q;
    flags_d  = flags_q;
    op_d     = op_q;
    start_c  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          op_d = bus.op;
          if (alu_multi_c) begin
            start_c = 1'b1;
            state_d = ST_EXEC;
          end else begin
            result_d = alu_res_c;
            hi_d     = alu_hi_c;
            flags_d  = alu_flags_c;
            acc_d    = alu_res_c;
            state_d  = ST_HOLD;
          end
        end
      end
      ST_EXEC: begin
        if (md_done && !md_busy) begin
          result_d        = md_lo;
          hi_d            = md_hi;
          acc_d           = md_lo;
          flags_d         = '0;
          flags_d[FLAG_Z] = (op_q == OP_MUL) ? ((md_lo == '0) && (md_hi == '0)) : (md_lo == '0);
          flags_d[FLAG_N] = md_lo[WIDTH-1];
          flags_d[FLAG_V] = (op_q == OP_MUL) && (md_hi != '0);
          state_d         = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (bus.out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      result_q    <= '0;
      hi_q        <= '0;
      acc_q       <= '0;
      flags_q     <= '0;
      op_q        <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else if (ena) begin
      state_q     <= state_d;
      result_q    <= result_d;
      hi_q        <= hi_d;
      acc_q       <= acc_d;
      flags_q     <= flags_d;
      op_q        <= op_d;
      in_ready_q  <= (state_d == ST_IDLE);
      out_valid_q <= (state_d == ST_HOLD);
    end
  end

`ifdef ALU_DIV_EN
  logic div_c;
  assign div_c = (bus.op == OP_DIV);
`endif

  alu_seq_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk     (clk),
    .rst     (rst),
    .ena_i   (ena),
    .start_i (start_c),
`ifdef ALU_DIV_EN
    .div_i   (div_c),
`endif
    .a_i     (opa_c),
    .b_i     (bus.b),
    .busy_o  (md_busy),
    .done_o  (md_done),
    .lo_o    (md_lo),
    .hi_o    (md_hi)
  );

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.result_hi = hi_q;
  assign bus.flags     = flags_q;

endmodule

// File: tb/tb_alu_seq_core.sv
// Self-checking bench for alu_seq_core (WIDTH=8) against an arithmetic reference model.
// Define ALU_DIV_EN for both bench and RTL to exercise the divider.
module tb_alu_seq_core;
  import alu_pkg::*;

  localparam int unsigned W = 8;

  logic clk = 1'b0;
  logic rst;
  logic ena;

  alu_seq_core_if #(.WIDTH(W)) bus ();

  alu_seq_core #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .ena (ena),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int acc_m       = 0;

  // Reference: result, high word, {Z,N,C,V} and whether the op is iterative
  function automatic void ref_model(input int op, input int av, input int bv,
                                    output int r, output int hi, output int fl, output bit multi);
    int mask, sa, sb, sv, sh, z, n, c, v, maxp, minn;
    longint p;
    mask = (1 << W) - 1;
    maxp = (1 << (W - 1)) - 1;
    minn = -(1 << (W - 1));
    sa = (av > maxp) ? av - (1 << W) : av;
    sb = (bv > maxp) ? bv - (1 << W) : bv;
    sh = bv % W;
    r = 0; hi = 0; c = 0; v = 0; multi = 1'b0;
    case (op)
      0: begin
        r = (av + bv) & mask; c = (av + bv) >> W;
        sv = sa + sb; v = (sv > maxp || sv < minn) ? 1 : 0;
      end
      1: begin
        r = (av - bv) & mask; c = (av < bv) ? 1 : 0;
        sv = sa - sb; v = (sv > maxp || sv < minn) ? 1 : 0;
      end
      2: r = av & bv;
      3: r = av | bv;
      4: r = av ^ bv;
      5: begin r = (av << sh) & mask; c = (sh == 0) ? 0 : ((av >> (W - sh)) & 1); end
      6: begin r = av >> sh;          c = (sh == 0) ? 0 : ((av >> (sh - 1)) & 1); end
      7: begin r = (sa >>> sh) & mask; c = (sh == 0) ? 0 : ((sa >>> (sh - 1)) & 1); end
      8: begin
        p = longint'(av) * longint'(bv);
        r = int'(p & longint'(mask)); hi = int'(p >> W);
        v = (hi != 0) ? 1 : 0; multi = 1'b1;
      end
`ifdef ALU_DIV_EN
      9: begin
        if (bv == 0) begin r = mask; hi = av; v = 1; end
        else begin r = av / bv; hi = av % bv; multi = 1'b1; end
      end
`endif
      10: r = bv;
      default: v = 1;
    endcase
    z = (op == 8) ? ((r == 0 && hi == 0) ? 1 : 0) : ((r == 0) ? 1 : 0);
    n = (r >> (W - 1)) & 1;
    fl = (z << 3) | (n << 2) | (c << 1) | v;
  endfunction

  // One full transaction: wait ready, present command, count cycles to out_valid, consume
  task automatic do_op(input int op, input bit sel, input int av, input int bv,
                       output int r, output int hi, output int fl, output int lat);
    int waited;
    waited = 0;
    @(negedge clk);
    while (bus.in_ready !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    bus.in_valid = 1'b1;
    bus.op       = 4'(op);
    bus.acc_sel  = sel;
    bus.a        = W'(av);
    bus.b        = W'(bv);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (bus.out_valid !== 1'b1 && lat < 100);
    r  = int'(bus.result);
    hi = int'(bus.result_hi);
    fl = int'(bus.flags);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    vectors++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_hs: in_ready=%b out_valid=%b, required 1/0", bus.in_ready, bus.out_valid);
    end
    vectors++;
    if (bus.result !== 8'h00 || bus.result_hi !== 8'h00 || bus.flags !== 4'h0) begin
      miscompares++;
      $display("FAIL reset_out: result=%h hi=%h flags=%h, required 00/00/0",
               bus.result, bus.result_hi, bus.flags);
    end
    acc_m = 0;
  endtask

  task automatic test_directed();
    int d_op[6] = '{0, 1, 8, 8, 9, 9};
    int d_a[6]  = '{'hFF, 'h80, 'h0F, 'hFF, 200, 'h55};
    int d_b[6]  = '{'h01, 'h01, 'h11, 'hFF, 7, 0};
    int er, eh, ef, r, hi, fl, lat, elat;
    bit multi;
    for (int i = 0; i < 6; i++) begin
      ref_model(d_op[i], d_a[i], d_b[i], er, eh, ef, multi);
      elat = multi ? W + 1 : 1;
      do_op(d_op[i], 1'b0, d_a[i], d_b[i], r, hi, fl, lat);
      acc_m = er;
      vectors++;
      if (r !== er || hi !== eh || fl !== ef) begin
        miscompares++;
        $display("FAIL directed[%0d] op=%0d: got r=%h hi=%h fl=%h, required r=%h hi=%h fl=%h",
                 i, d_op[i], r, hi, fl, er, eh, ef);
      end
      vectors++;
      if (lat !== elat) begin
        miscompares++;
        $display("FAIL directed_lat[%0d] op=%0d: latency %0d, required %0d", i, d_op[i], lat, elat);
      end
    end
  endtask

  task automatic test_backpressure();
    int er, eh, ef;
    bit multi;
    ref_model(0, 'h33, 'h44, er, eh, ef, multi);
    @(negedge clk);
    bus.in_valid = 1'b1; bus.op = 4'(0); bus.acc_sel = 1'b0; bus.a = 8'h33; bus.b = 8'h44;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      vectors++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || int'(bus.result) !== er) begin
        miscompares++;
        $display("FAIL backpressure[%0d]: out_valid=%b in_ready=%b result=%h, required 1/0/%h",
                 k, bus.out_valid, bus.in_ready, bus.result, er);
      end
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    acc_m = er;
  endtask

  task automatic test_acc();
    int er, eh, ef, r, hi, fl, lat;
    bit multi;
    ref_model(10, 0, 'h10, er, eh, ef, multi);
    do_op(10, 1'b0, 'hAA, 'h10, r, hi, fl, lat);
    acc_m = er;
    ref_model(0, acc_m, 'h05, er, eh, ef, multi);
    do_op(0, 1'b1, 'hC3, 'h05, r, hi, fl, lat);
    acc_m = er;
    vectors++;
    if (r !== 'h15 || r !== er || fl !== ef) begin
      miscompares++;
      $display("FAIL acc_chain: result=%h flags=%h, required 15 flags=%h", r, fl, ef);
    end
  endtask

  task automatic test_random();
    int op, av, bv, aeff, er, eh, ef, r, hi, fl, lat, elat;
    bit sel, multi;
    for (int i = 0; i < 80; i++) begin
      op  = int'($urandom_range(0, 15));
      av  = int'($urandom_range(0, 255));
      bv  = int'($urandom_range(0, 255));
      sel = 1'($urandom_range(0, 1));
      if (op == 9 && $urandom_range(0, 3) == 0) bv = 0;
      aeff = sel ? acc_m : av;
      ref_model(op, aeff, bv, er, eh, ef, multi);
      elat = multi ? W + 1 : 1;
      do_op(op, sel, av, bv, r, hi, fl, lat);
      acc_m = er;
      vectors++;
      if (r !== er || hi !== eh || fl !== ef || lat !== elat) begin
        miscompares++;
        $display("FAIL random[%0d] op=%0d a=%h b=%h sel=%b: got r=%h hi=%h fl=%h lat=%0d, required r=%h hi=%h fl=%h lat=%0d",
                 i, op, aeff, bv, sel, r, hi, fl, lat, er, eh, ef, elat);
      end
    end
  endtask

  task automatic test_reset_mid();
    int er, eh, ef, r, hi, fl, lat;
    bit multi;
    @(negedge clk);
    bus.in_valid = 1'b1; bus.op = 4'(8); bus.acc_sel = 1'b0; bus.a = 8'h0F; bus.b = 8'h11;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    acc_m = 0;
    @(negedge clk);
    vectors++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.result !== 8'h00 ||
        bus.result_hi !== 8'h00 || bus.flags !== 4'h0) begin
      miscompares++;
      $display("FAIL reset_mid: in_ready=%b out_valid=%b result=%h hi=%h flags=%h, required 1/0/00/00/0",
               bus.in_ready, bus.out_valid, bus.result, bus.result_hi, bus.flags);
    end
    repeat (W + 2) @(negedge clk);
    vectors++;
    if (bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_stale: out_valid=%b, required 0", bus.out_valid);
    end
    ref_model(0, acc_m, 0, er, eh, ef, multi);
    do_op(0, 1'b1, 'h77, 0, r, hi, fl, lat);
    acc_m = er;
    vectors++;
    if (r !== 0 || r !== er || fl !== ef) begin
      miscompares++;
      $display("FAIL reset_mid_acc: result=%h flags=%h, required 00 flags=%h", r, fl, ef);
    end
  endtask

  task automatic test_ena();
    int av, bv, er, eh, ef, lat;
    bit multi;
    av = int'($urandom_range(0, 255));
    bv = int'($urandom_range(0, 255));
    ref_model(8, av, bv, er, eh, ef, multi);
    @(negedge clk);
    bus.in_valid = 1'b1; bus.op = 4'(8); bus.acc_sel = 1'b0; bus.a = W'(av); bus.b = W'(bv);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 3) ena = 1'b0;
      if (lat == 7) ena = 1'b1;
    end while (bus.out_valid !== 1'b1 && lat < 100);
    ena = 1'b1;
    vectors++;
    if (lat !== 13 || int'(bus.result) !== er || int'(bus.result_hi) !== eh || int'(bus.flags) !== ef) begin
      miscompares++;
      $display("FAIL ena_stretch: lat=%0d r=%h hi=%h fl=%h, required lat=13 r=%h hi=%h fl=%h",
               lat, bus.result, bus.result_hi, bus.flags, er, eh, ef);
    end
    acc_m = er;
    // Frozen core must ignore out_ready while holding its result
    ena = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      vectors++;
      if (bus.out_valid !== 1'b1 || int'(bus.result) !== er) begin
        miscompares++;
        $display("FAIL ena_hold: out_valid=%b result=%h, required 1/%h", bus.out_valid, bus.result, er);
      end
    end
    ena = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    @(negedge clk);
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL ena_release: out_valid=%b in_ready=%b, required 0/1", bus.out_valid, bus.in_ready);
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.op        = '0;
    bus.acc_sel   = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b0;
    rst           = 1'b1;
    ena           = 1'b1;
    test_reset();
    test_directed();
    test_backpressure();
    test_acc();
    test_random();
    test_reset_mid();
    test_ena();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
